// File: rtl/mem_access_pkg.sv
// Shared types for the data-memory access sequencer: FSM states, address source, timeout default.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } mem_seq_state_e;

    typedef enum logic {
        ADDR_LIT  = 1'b0,
        ADDR_REGB = 1'b1
    } addr_src_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 15;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Per-phase wait counter; expired_o flags the LIMIT-th cycle spent in the current phase.
// Latency: combinational expired_o from the count register; no backpressure.
module mem_timeout_cnt #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] MAX  = W'(LIMIT);

    logic [W-1:0] r_cnt;

    // Saturates at LIMIT so a long stall cannot wrap back to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (enable_i && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired_o = enable_i && (r_cnt == LAST);

endmodule

// File: rtl/mem_access_seq.sv
// Load/store sequencer: req/gnt/rvalid handshake with data memory, stalls the core via busy_o.
// Latency: store done 2 cycles after accept, load done 3; optional timeout under MEM_ACCESS_SEQ_TIMEOUT_EN.
import mem_access_pkg::*;

module mem_access_seq #(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       we_i,
    input  logic       addr_src_i,
    input  logic [7:0] wdata_i,
    output logic       sel_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic [7:0] mem_wdata_o,
    input  logic       mem_gnt_i,
    input  logic       mem_rvalid_i,
    input  logic [7:0] mem_rdata_i,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    mem_seq_state_e r_state;
    mem_seq_state_e w_next;
    logic           r_we;
    addr_src_e      r_sel;
    logic [7:0]     r_wdata;
    logic [7:0]     r_rdata;
    logic           w_expired;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A gnt/rvalid in the limit cycle is checked first, so it completes normally.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) w_next = REQ;
            end
            REQ: begin
                if (mem_gnt_i)      w_next = r_we ? DONE : WAIT_R;
                else if (w_expired) w_next = DONE;
            end
            WAIT_R: begin
                if (mem_rvalid_i)   w_next = DONE;
                else if (w_expired) w_next = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o    = (r_state != IDLE);
        mem_req_o = (r_state == REQ);
        mem_we_o  = (r_state == REQ) && r_we;
        done_o    = (r_state == DONE);
    end

    // Command fields stay latched after completion so the mux address is stable into IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we    <= 1'b0;
            r_sel   <= ADDR_LIT;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
        end else begin
            if ((r_state == IDLE) && start_i) begin
                r_we    <= we_i;
                r_sel   <= addr_src_e'(addr_src_i);
                r_wdata <= wdata_i;
            end
            if ((r_state == WAIT_R) && mem_rvalid_i) begin
                r_rdata <= mem_rdata_i;
            end
        end
    end

    assign sel_o       = r_sel;
    assign mem_wdata_o = r_wdata;
    assign rdata_o     = r_rdata;

`ifdef MEM_ACCESS_SEQ_TIMEOUT_EN
    logic w_cnt_clear;
    logic w_cnt_en;
    logic w_timeout;
    logic r_err;

    assign w_cnt_clear = (w_next != r_state) && ((w_next == REQ) || (w_next == WAIT_R));
    assign w_cnt_en    = (r_state == REQ) || (r_state == WAIT_R);
    assign w_timeout   = w_expired && (((r_state == REQ) && !mem_gnt_i) ||
                                       ((r_state == WAIT_R) && !mem_rvalid_i));

    mem_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (w_cnt_clear),
        .enable_i  (w_cnt_en),
        .expired_o (w_expired)
    );

    // Set only on the edge entering DONE, so it pulses together with done_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign err_o = r_err;
`else
    assign w_expired = 1'b0;
    assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_seq.sv
// Randomised and directed checks of mem_access_seq against a cycle-count reference model.
module tb_mem_access_seq;

    localparam int TO = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic       we_i = 1'b0;
    logic       addr_src_i = 1'b0;
    logic [7:0] wdata_i = 8'h00;
    logic       sel_o;
    logic       mem_req_o;
    logic       mem_we_o;
    logic [7:0] mem_wdata_o;
    logic       mem_gnt_i = 1'b0;
    logic       mem_rvalid_i = 1'b0;
    logic [7:0] mem_rdata_i = 8'h00;
    logic [7:0] rdata_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] model_rdata = 8'h00;

    mem_access_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .we_i         (we_i),
        .addr_src_i   (addr_src_i),
        .wdata_i      (wdata_i),
        .sel_o        (sel_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .rdata_o      (rdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issues one command in the current cycle (cycle 0) and monitors it until busy_o drops.
    // gcyc/rcyc: cycle numbers at which gnt/rvalid are presented (<=0 means never).
    task automatic do_access(input bit we, input bit src, input logic [7:0] wd,
                             input int gcyc, input int rcyc, input logic [7:0] rb,
                             output int done_at, output int n_done, output int n_req,
                             output int n_err, output int err_at, output int idle_at,
                             output bit sel_bad, output bit we_bad, output bit wd_bad);
        done_at = -1; n_done = 0; n_req = 0; n_err = 0; err_at = -1; idle_at = -1;
        sel_bad = 0; we_bad = 0; wd_bad = 0;
        start_i = 1'b1; we_i = we; addr_src_i = src; wdata_i = wd;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            tick();
            if (mem_req_o) n_req++;
            if (done_o) begin n_done++; done_at = c; end
            if (err_o) begin n_err++; err_at = c; end
            if (sel_o !== src) sel_bad = 1;
            if (mem_wdata_o !== wd) wd_bad = 1;
            if (mem_req_o && (mem_we_o !== we)) we_bad = 1;
            if (!mem_req_o && (mem_we_o !== 1'b0)) we_bad = 1;
            if (!busy_o) begin idle_at = c; break; end
            // While busy, start and command fields are noise that must be ignored.
            start_i = 1'($urandom); we_i = 1'($urandom);
            addr_src_i = 1'($urandom); wdata_i = 8'($urandom);
            mem_gnt_i = (c == gcyc);
            if (c == rcyc) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = rb;
            end else if (c <= gcyc) begin
                mem_rvalid_i = 1'($urandom); mem_rdata_i = 8'($urandom);
            end else begin
                mem_rvalid_i = 1'b0;
            end
        end
        start_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick(); tick();
        n_checks++; if ({busy_o, mem_req_o, mem_we_o, done_o, err_o, sel_o} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {busy_o, mem_req_o, mem_we_o, done_o, err_o, sel_o}); end
        n_checks++; if ({mem_wdata_o, rdata_o} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0000", {mem_wdata_o, rdata_o}); end
        rst_ni = 1'b1;
        tick();
        n_checks++; if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy got %b expected 0", busy_o); end
    endtask

    task automatic test_store();
        int d, nd, nr, ne, ea, ia; bit sb, wb, db;
        do_access(1'b1, 1'b1, 8'hA5, 1, 0, 8'h00, d, nd, nr, ne, ea, ia, sb, wb, db);
        n_checks++; if (d !== 2 || nd !== 1) begin
            n_fail++; $display("FAIL store_done: at %0d count %0d, expected at 2 count 1", d, nd); end
        n_checks++; if (ia !== 3) begin
            n_fail++; $display("FAIL store_idle: got cycle %0d expected 3", ia); end
        n_checks++; if (nr !== 1 || wb) begin
            n_fail++; $display("FAIL store_req_we: req cycles %0d we_bad %0d, expected 1 and 0", nr, wb); end
        n_checks++; if (sb || db) begin
            n_fail++; $display("FAIL store_sel_wdata: sel_bad %0d wdata_bad %0d expected 0 0", sb, db); end
        n_checks++; if (ne !== 0 || rdata_o !== model_rdata) begin
            n_fail++; $display("FAIL store_side: err %0d rdata %h, expected 0 and %h", ne, rdata_o, model_rdata); end
    endtask

    task automatic test_load();
        int d, nd, nr, ne, ea, ia; bit sb, wb, db;
        // gnt after 3 waiting REQ cycles, rvalid in the second WAIT_R cycle
        do_access(1'b0, 1'b0, 8'h77, 4, 6, 8'h3C, d, nd, nr, ne, ea, ia, sb, wb, db);
        model_rdata = 8'h3C;
        n_checks++; if (d !== 7 || nd !== 1 || ia !== 8) begin
            n_fail++; $display("FAIL load_timing: done %0d x%0d idle %0d, expected 7 x1 8", d, nd, ia); end
        n_checks++; if (rdata_o !== 8'h3C) begin
            n_fail++; $display("FAIL load_rdata: got %h expected 3c", rdata_o); end
        n_checks++; if (sb || wb || nr !== 4) begin
            n_fail++; $display("FAIL load_sel_req: sel_bad %0d we_bad %0d req %0d, expected 0 0 4", sb, wb, nr); end
    endtask

    task automatic test_start_held();
        int acc[$];
        bit prev_busy;
        int req_run;
        logic [7:0] wd5;
        prev_busy = busy_o; req_run = 0; wd5 = 8'h00;
        for (int c = 0; c < 12; c++) begin
            if (busy_o && !prev_busy) acc.push_back(c - 1);
            prev_busy = busy_o;
            if (c == 5) wd5 = mem_wdata_o;
            req_run = mem_req_o ? req_run + 1 : 0;
            mem_gnt_i = mem_req_o && (req_run == 2);
            start_i = (c < 6); we_i = 1'b1; addr_src_i = 1'b0;
            wdata_i = 8'(8'h10 + c);
            tick();
        end
        start_i = 1'b0; mem_gnt_i = 1'b0;
        n_checks++; if (acc.size() !== 2) begin
            n_fail++; $display("FAIL held_accept_count: got %0d expected 2", acc.size()); end
        n_checks++; if (acc.size() < 2 || acc[0] !== 0 || acc[1] !== 4) begin
            n_fail++; $display("FAIL held_accept_cycles: got %p expected 0 and 4", acc); end
        n_checks++; if (wd5 !== 8'h14) begin
            n_fail++; $display("FAIL held_wdata: got %h expected 14", wd5); end
    endtask

    task automatic test_random();
        int d, nd, nr, ne, ea, ia, gc, rc, exp_done; bit sb, wb, db, we, src;
        logic [7:0] wd, rb;
        for (int t = 0; t < 25; t++) begin
            we = 1'($urandom); src = 1'($urandom); wd = 8'($urandom); rb = 8'($urandom);
            gc = 1 + $urandom_range(0, TO - 1);
            rc = we ? 0 : gc + 1 + $urandom_range(0, TO - 1);
            do_access(we, src, wd, gc, rc, rb, d, nd, nr, ne, ea, ia, sb, wb, db);
            exp_done = we ? gc + 1 : rc + 1;
            if (!we) model_rdata = rb;
            n_checks++; if (d !== exp_done || nd !== 1 || ia !== exp_done + 1) begin
                n_fail++; $display("FAIL rand_timing[%0d]: done %0d x%0d idle %0d, expected %0d x1 %0d", t, d, nd, ia, exp_done, exp_done + 1); end
            n_checks++; if (nr !== gc || ne !== 0 || sb || wb || db) begin
                n_fail++; $display("FAIL rand_signals[%0d]: req %0d err %0d flags %0d%0d%0d, expected %0d 0 000", t, nr, ne, sb, wb, db, gc); end
            n_checks++; if (rdata_o !== model_rdata) begin
                n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h", t, rdata_o, model_rdata); end
            // stray rvalid while idle must not touch rdata_o
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = 8'($urandom);
                tick();
            end
            mem_rvalid_i = 1'b0;
            n_checks++; if (rdata_o !== model_rdata) begin
                n_fail++; $display("FAIL rand_idle_rvalid[%0d]: got %h expected %h", t, rdata_o, model_rdata); end
        end
    endtask

`ifdef MEM_ACCESS_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int d, nd, nr, ne, ea, ia; bit sb, wb, db;
        do_access(1'b1, 1'b0, 8'h11, 0, 0, 8'h00, d, nd, nr, ne, ea, ia, sb, wb, db);
        n_checks++; if (d !== TO + 1 || ea !== TO + 1 || ne !== 1 || nd !== 1) begin
            n_fail++; $display("FAIL to_gnt: done %0d err %0d x%0d, expected both %0d x1", d, ea, ne, TO + 1); end
        n_checks++; if (nr !== TO || rdata_o !== model_rdata) begin
            n_fail++; $display("FAIL to_gnt_side: req %0d rdata %h, expected %0d %h", nr, rdata_o, TO, model_rdata); end
        do_access(1'b1, 1'b1, 8'h22, TO, 0, 8'h00, d, nd, nr, ne, ea, ia, sb, wb, db);
        n_checks++; if (d !== TO + 1 || ne !== 0) begin
            n_fail++; $display("FAIL to_gnt_on_limit: done %0d err %0d, expected %0d 0", d, ne, TO + 1); end
        do_access(1'b0, 1'b1, 8'h33, 1, 0, 8'hEE, d, nd, nr, ne, ea, ia, sb, wb, db);
        n_checks++; if (d !== TO + 2 || ea !== TO + 2 || ne !== 1 || rdata_o !== model_rdata) begin
            n_fail++; $display("FAIL to_rvalid: done %0d err %0d rdata %h, expected %0d %0d %h", d, ea, rdata_o, TO + 2, TO + 2, model_rdata); end
        do_access(1'b0, 1'b0, 8'h44, 1, TO + 1, 8'hC3, d, nd, nr, ne, ea, ia, sb, wb, db);
        model_rdata = 8'hC3;
        n_checks++; if (d !== TO + 2 || ne !== 0 || rdata_o !== 8'hC3) begin
            n_fail++; $display("FAIL to_rvalid_on_limit: done %0d err %0d rdata %h, expected %0d 0 c3", d, ne, rdata_o, TO + 2); end
    endtask
`endif

    task automatic test_reset_mid();
        int d, nd, nr, ne, ea, ia, n_done; bit sb, wb, db;
        start_i = 1'b1; we_i = 1'b0; addr_src_i = 1'b1; wdata_i = 8'h5A;
        tick();
        start_i = 1'b0; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        n_checks++; if (busy_o !== 1'b1 || mem_req_o !== 1'b0 || sel_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_in_wait: busy %b req %b sel %b, expected 1 0 1", busy_o, mem_req_o, sel_o); end
        #2 rst_ni = 1'b0;
        #1;
        n_checks++; if ({busy_o, mem_req_o, mem_we_o, done_o, err_o, sel_o} !== 6'b0 || {mem_wdata_o, rdata_o} !== 16'h0000) begin
            n_fail++; $display("FAIL rstmid_async: ctrl %b data %h, expected 0", {busy_o, mem_req_o, mem_we_o, done_o, err_o, sel_o}, {mem_wdata_o, rdata_o}); end
        model_rdata = 8'h00;
        n_done = 0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 8'h99;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done_o || err_o) n_done++;
        end
        mem_rvalid_i = 1'b0;
        #3 rst_ni = 1'b1;
        tick();
        n_checks++; if (n_done !== 0 || busy_o !== 1'b0 || rdata_o !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_quiet: done/err %0d busy %b rdata %h, expected 0 0 00", n_done, busy_o, rdata_o); end
        do_access(1'b0, 1'b0, 8'h00, 1, 2, 8'h6B, d, nd, nr, ne, ea, ia, sb, wb, db);
        n_checks++; if (d !== 3 || nd !== 1 || rdata_o !== 8'h6B) begin
            n_fail++; $display("FAIL rstmid_recover: done %0d x%0d rdata %h, expected 3 x1 6b", d, nd, rdata_o); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_start_held();
        test_random();
`ifdef MEM_ACCESS_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Multi-cycle data-memory access sequencer for the 8-bit core. It accepts one load or store command at a time from the control unit and drives the data-address multiplexer select, choosing between the instruction literal and register B. It runs a req/gnt/rvalid handshake with data memory and stalls the core via `busy_o` until the access completes. It sits between the control unit, the address mux and the data-memory port.

## Interface
- `TIMEOUT_CYCLES`, default 15: maximum wait cycles per handshake phase; only used when the timeout is compiled in (see Configuration).
- `clk_i`  in  1  system clock, rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  command strobe; accepted only while `busy_o`=0.
- `we_i`  in  1  1 = store, 0 = load; sampled with `start_i`.
- `addr_src_i`  in  1  0 = instruction literal, 1 = register B; sampled with `start_i`.
- `wdata_i`  in  8  store data (register A); sampled with `start_i`.
- `sel_o`  out  1  address-mux select; drives the mux select input.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  write enable; valid only with `mem_req_o`.
- `mem_wdata_o`  out  8  latched store data.
- `mem_gnt_i`  in  1  request accepted.
- `mem_rvalid_i`  in  1  read data valid.
- `mem_rdata_i`  in  8  read data.
- `rdata_o`  out  8  last loaded byte; held until the next load completes.
- `busy_o`  out  1  stall to core; 1 whenever state ≠ IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  one-cycle timeout pulse; coincides with `done_o`.

## Operation
- **FSM states:** IDLE, REQ, WAIT_R, DONE.
- **IDLE:**
  - `start_i`=1 latches `we_i`, `addr_src_i` and `wdata_i`; the FSM moves to REQ.
  - `start_i` is ignored in every other state.
- **REQ:**
  - `mem_req_o`=1 and `mem_we_o`=latched we.
  - On `mem_gnt_i`: a store goes to DONE; a load goes to WAIT_R.
- **WAIT_R:**
  - On `mem_rvalid_i`: capture `mem_rdata_i` into `rdata_o` and go to DONE.
  - `mem_rvalid_i` seen in any state other than WAIT_R is ignored.
- **DONE:** `done_o`=1 for one cycle, then the FSM returns to IDLE.
- **Select hold:** `sel_o` equals the latched source from the accept cycle through DONE and keeps that value in IDLE until the next accepted command. The mux address is therefore stable for the whole access.
- **`mem_wdata_o`:** holds the latched `wdata_i`.

## Timing
- **Reset values:** state IDLE; `sel_o`, `mem_req_o`, `mem_we_o`, `busy_o`, `done_o` and `err_o` = 0; `mem_wdata_o` and `rdata_o` = 8'h00.
- **Reset mid-operation:**
  - Outputs go to their reset values immediately (asynchronous).
  - The request is dropped, with no `done_o` and no `err_o`.
- **Store latency, gnt in first REQ cycle:**
  - start accepted at cycle 0.
  - `mem_req_o` high at cycle 1.
  - `done_o` at cycle 2.
  - IDLE (`busy_o`=0) at cycle 3.
- **Load latency, gnt at cycle 1 and rvalid at cycle 2:** `done_o` at cycle 3; `rdata_o` updates at the edge ending cycle 2.
- **Back-to-back commands:** earliest next accept is the cycle after DONE, so the minimum issue interval is 3 cycles.
- **Registered outputs:** all outputs are registered or decoded directly from state; there are no combinational input→output paths.

## Configuration
- Macro: `MEM_ACCESS_SEQ_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to REQ and on entry to WAIT_R, and increments each cycle in those states.
  - When it reaches `TIMEOUT_CYCLES` without the awaited gnt/rvalid, the FSM goes to DONE with `err_o`=1 and `done_o`=1.
  - On timeout, `rdata_o` is unchanged.
  - A gnt/rvalid arriving in the same cycle as the limit wins: it counts as a normal completion with no error.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- **Undefined:**
  - No counter; the FSM waits indefinitely.
  - `err_o` is tied 0.
  - `TIMEOUT_CYCLES` is unused.

## Structure
- **Package `mem_access_pkg`:**
  - `mem_seq_state_e` (IDLE, REQ, WAIT_R, DONE).
  - `addr_src_e` (`ADDR_LIT`=1'b0, `ADDR_REGB`=1'b1).
  - Default `TIMEOUT_CYCLES` constant.
- **Sub-module `mem_timeout_cnt`:** instantiated only under the macro. Ports: clear, enable, `expired_o`.

## Test plan
- Store, `addr_src_i`=1, `wdata_i`=8'hA5, gnt in first REQ cycle → `sel_o`=1 from cycle 1, `mem_we_o`=1, `mem_wdata_o`=8'hA5, `done_o` at cycle 2, `busy_o`=0 at cycle 3.
- Load, `addr_src_i`=0, gnt delayed 3 cycles, rvalid 2 cycles later with 8'h3C → `rdata_o`=8'h3C, a single `done_o` pulse, `sel_o`=0 throughout.
- `start_i` held high for 6 cycles → exactly two commands accepted (cycles 0 and 4); starts in busy cycles are ignored.
- `rst_ni` asserted in WAIT_R → all outputs 0 asynchronously, no `done_o`; after release, a new load completes normally.
- Timeout build, `TIMEOUT_CYCLES`=4, gnt never asserted → `done_o`=`err_o`=1 five cycles after accept, `rdata_o` unchanged.
- Timeout build, gnt arrives exactly on the limit cycle → normal completion, `err_o`=0.
